// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chess_pkg
// Description : Shared board constants, piece encoding and material values
//               for the material evaluator and its board-port arbiter.
// Contents    : SQUARES / ADDR_W / PIECE_W / SCORE_W / STARVE_LIMIT,
//               colour constants, piece_type_e, piece_t {color, ptype},
//               piece_value(), evaluator FSM state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package chess_pkg;

  localparam int SQUARES      = 64;
  localparam int ADDR_W       = $clog2(SQUARES);
  localparam int PIECE_W      = 4;
  localparam int SCORE_W      = 16;
  localparam int STARVE_LIMIT = 4;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    PAWN    = 3'd1,
    KNIGHT  = 3'd2,
    BISHOP  = 3'd3,
    ROOK    = 3'd4,
    QUEEN   = 3'd5,
    KING    = 3'd6,
    INVALID = 3'd7
  } piece_type_e;

  typedef struct packed {
    logic        color;
    piece_type_e ptype;
  } piece_t;

  // King is scored 0: both sides always have one, so it never changes balance.
  function automatic logic [3:0] piece_value(input piece_type_e t);
    logic [3:0] v;
    v = 4'd0;
    case (t)
      PAWN:           v = 4'd1;
      KNIGHT, BISHOP: v = 4'd3;
      ROOK:           v = 4'd5;
      QUEEN:          v = 4'd10;
      default:        v = 4'd0;
    endcase
    return v;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } eval_state_e;

endpackage
`default_nettype wire

// File: rtl/material_eval_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : material_eval_seq_if
// Description : Bundle between the evaluator, the search controller, the
//               move generator and the board RAM.
// Modports    : slave  - evaluator side (start/ram_rdata/mg_req/mg_addr in;
//                        busy/done/score/ram_rd_en/ram_addr/mg_gnt/mg_rvalid out)
//               master - environment side (mirror of slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface material_eval_seq_if #(
  parameter int PIECE_W = chess_pkg::PIECE_W,
  parameter int SCORE_W = chess_pkg::SCORE_W,
  parameter int ADDR_W  = chess_pkg::ADDR_W
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic signed [SCORE_W-1:0] score;
  logic                      ram_rd_en;
  logic [ADDR_W-1:0]         ram_addr;
  logic [PIECE_W-1:0]        ram_rdata;
  logic                      mg_req;
  logic [ADDR_W-1:0]         mg_addr;
  logic                      mg_gnt;
  logic                      mg_rvalid;

  modport slave (
    input  start, ram_rdata, mg_req, mg_addr,
    output busy, done, score, ram_rd_en, ram_addr, mg_gnt, mg_rvalid
  );

  modport master (
    output start, ram_rdata, mg_req, mg_addr,
    input  busy, done, score, ram_rd_en, ram_addr, mg_gnt, mg_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/board_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : board_port_arb
// Description : Two-requester arbiter for the single board-RAM read port.
//               Move generator has priority; the evaluator wins when the
//               generator is idle or after STARVE_LIMIT consecutive denials.
// Ports       : clk, rst; eval_req/eval_addr, mg_req/mg_addr in;
//               ram_rd_en/ram_addr, mg_gnt/mg_rvalid, eval_gnt/eval_rvalid out
// Revision    : 1.0 - initial release
// ============================================================================
module board_port_arb #(
  parameter int ADDR_W       = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              eval_req,
  input  wire logic [ADDR_W-1:0] eval_addr,
  input  wire logic              mg_req,
  input  wire logic [ADDR_W-1:0] mg_addr,
  output logic                   ram_rd_en,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   mg_gnt,
  output logic                   mg_rvalid,
  output logic                   eval_gnt,
  output logic                   eval_rvalid
);

  localparam int c_cnt_w = $clog2(STARVE_LIMIT + 1);

  logic [c_cnt_w-1:0] r_starve;
  logic               r_rd_vld;
  logic               r_owner_eval;

  // eval_req is only raised while scanning, so outside a scan mg_gnt == mg_req.
  always_comb begin
    eval_gnt    = eval_req && (!mg_req || (r_starve == c_cnt_w'(STARVE_LIMIT)));
    mg_gnt      = mg_req && !eval_gnt;
    ram_rd_en   = eval_gnt || mg_gnt;
    ram_addr    = eval_gnt ? eval_addr : mg_addr;
    mg_rvalid   = r_rd_vld && !r_owner_eval;
    eval_rvalid = r_rd_vld && r_owner_eval;
  end

  // Owner tag travels with the read so the returning data can be steered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve     <= '0;
      r_rd_vld     <= 1'b0;
      r_owner_eval <= 1'b0;
    end else begin
      r_rd_vld     <= ram_rd_en;
      r_owner_eval <= eval_gnt;
      if (eval_gnt) begin
        r_starve <= '0;
      end else if (eval_req && mg_req) begin
        r_starve <= r_starve + c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/material_eval_seq.sv
`default_nettype none
// ============================================================================
// Module      : material_eval_seq
// Description : Sequenced material evaluator. On start, reads all squares of
//               the board RAM (sharing the port with the move generator) and
//               accumulates white-minus-black material into a signed score.
// Ports       : clk, rst (sync, active-high);
//               bus (material_eval_seq_if.slave): start/busy/done/score,
//               ram_rd_en/ram_addr/ram_rdata, mg_req/mg_addr/mg_gnt/mg_rvalid
// Revision    : 1.0 - initial release
// ============================================================================
module material_eval_seq
  import chess_pkg::*;
#(
  parameter int SQUARES      = chess_pkg::SQUARES,
  parameter int SCORE_W      = chess_pkg::SCORE_W,
  parameter int STARVE_LIMIT = chess_pkg::STARVE_LIMIT
) (
  input  wire logic          clk,
  input  wire logic          rst,
  material_eval_seq_if.slave bus
);

  localparam int c_addr_w = $clog2(SQUARES);
  localparam logic [c_addr_w-1:0] c_last_sq = c_addr_w'(SQUARES - 1);

  eval_state_e               r_state;
  eval_state_e               w_state_next;
  logic [c_addr_w-1:0]       r_idx;
  logic signed [SCORE_W-1:0] r_acc;
  logic signed [SCORE_W-1:0] r_score;
  logic signed [SCORE_W-1:0] w_acc_next;
  logic signed [SCORE_W-1:0] w_val_ext;
  piece_t                    w_piece;
  logic                      w_eval_req;
  logic                      w_eval_gnt;
  logic                      w_eval_rvalid;
  logic                      w_busy;
  logic                      w_done;

  board_port_arb #(
    .ADDR_W       (c_addr_w),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .eval_req    (w_eval_req),
    .eval_addr   (r_idx),
    .mg_req      (bus.mg_req),
    .mg_addr     (bus.mg_addr),
    .ram_rd_en   (bus.ram_rd_en),
    .ram_addr    (bus.ram_addr),
    .mg_gnt      (bus.mg_gnt),
    .mg_rvalid   (bus.mg_rvalid),
    .eval_gnt    (w_eval_gnt),
    .eval_rvalid (w_eval_rvalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_eval_req   = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_eval_req = 1'b1;
        if (w_eval_gnt && (r_idx == c_last_sq)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_eval_rvalid) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Piece value is zero-extended, then added or subtracted by colour.
  always_comb begin
    w_piece    = piece_t'(bus.ram_rdata);
    w_val_ext  = $signed({{(SCORE_W-4){1'b0}}, piece_value(w_piece.ptype)});
    w_acc_next = r_acc;
    case (w_piece.color)
      COLOR_WHITE: w_acc_next = r_acc + w_val_ext;
      COLOR_BLACK: w_acc_next = r_acc - w_val_ext;
      default:     w_acc_next = r_acc;
    endcase
  end

  // score is loaded with the final sum on entry to DONE so it is already
  // valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_acc   <= '0;
      r_score <= '0;
    end else begin
      if ((r_state == ST_IDLE) && bus.start) begin
        r_idx <= '0;
        r_acc <= '0;
      end
      if (w_eval_gnt) begin
        r_idx <= r_idx + c_addr_w'(1);
      end
      if (w_eval_rvalid) begin
        r_acc <= w_acc_next;
      end
      if ((r_state == ST_DRAIN) && (w_state_next == ST_DONE)) begin
        r_score <= w_acc_next;
      end
    end
  end

  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.score = r_score;

endmodule
`default_nettype wire

// File: tb/tb_material_eval_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_material_eval_seq
// Description : Self-checking bench for material_eval_seq with a board-RAM
//               model and a material/arbitration reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_material_eval_seq;
  import chess_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  material_eval_seq_if bus ();

  material_eval_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [3:0] board [SQUARES];
  logic [3:0] saved [SQUARES];

  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_rdata <= board[bus.ram_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int val_tab [8] = '{0, 1, 3, 3, 5, 10, 0, 0};

  function automatic int model_score();
    int s;
    s = 0;
    for (int i = 0; i < SQUARES; i++) begin
      logic [3:0] c;
      c = board[i];
      if (c[3]) s -= val_tab[c[2:0]];
      else      s += val_tab[c[2:0]];
    end
    return s;
  endfunction

  task automatic clear_board();
    for (int i = 0; i < SQUARES; i++) board[i] = 4'h0;
  endtask

  task automatic random_board();
    for (int i = 0; i < SQUARES; i++)
      board[i] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
  endtask

  task automatic load_std();
    logic [3:0] back [8];
    back = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    clear_board();
    for (int i = 0; i < 8; i++) begin
      board[i]      = back[i];
      board[8 + i]  = 4'h1;
      board[48 + i] = 4'h9;
      board[56 + i] = back[i] | 4'h8;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.mg_req = 1'b0; bus.mg_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulses start and counts cycles until done (start cycle = 0).
  task automatic run_scan(output int lat, output int sc);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; lat = 1; #1;
    while (bus.done !== 1'b1 && lat < 1000) begin
      @(negedge clk); lat++; #1;
    end
    sc = int'($signed(bus.score));
  endtask

  task automatic test_reset();
    do_reset(); #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.score !== 16'sd0) $display("FAIL reset_score: got %0d want 0", bus.score); else n_pass++;
    n_checks++; if (bus.ram_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.ram_rd_en); else n_pass++;
    n_checks++; if (bus.mg_gnt !== 1'b0) $display("FAIL reset_mg_gnt: got %b want 0", bus.mg_gnt); else n_pass++;
    n_checks++; if (bus.mg_rvalid !== 1'b0) $display("FAIL reset_mg_rvalid: got %b want 0", bus.mg_rvalid); else n_pass++;
  endtask

  task automatic test_empty_latency();
    int lat, sc;
    clear_board();
    run_scan(lat, sc);
    n_checks++; if (lat != 66) $display("FAIL empty_latency: got %0d want 66", lat); else n_pass++;
    n_checks++; if (sc != 0) $display("FAIL empty_score: got %0d want 0", sc); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL empty_busy_after: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL empty_done_pulse: got %b want 0", bus.done); else n_pass++;
  endtask

  task automatic test_material();
    int lat, sc, exp;
    load_std(); run_scan(lat, sc);
    n_checks++; if (sc != 0) $display("FAIL std_score: got %0d want 0", sc); else n_pass++;
    board[59] = 4'h0; run_scan(lat, sc);
    n_checks++; if (sc != 10) $display("FAIL no_bq_score: got %0d want 10", sc); else n_pass++;
    n_checks++; if (lat != 66) $display("FAIL no_bq_latency: got %0d want 66", lat); else n_pass++;
    clear_board(); board[0] = 4'hC; board[63] = 4'h1; run_scan(lat, sc);
    n_checks++; if (sc != -4) $display("FAIL rook_pawn_score: got %0d want -4", sc); else n_pass++;
    for (int i = 0; i < SQUARES; i++) begin
      logic [3:0] z [4];
      z = '{4'h0, 4'h7, 4'h8, 4'hF};
      board[i] = z[$urandom_range(0, 3)];
    end
    run_scan(lat, sc);
    n_checks++; if (sc != 0) $display("FAIL zero_codes_score: got %0d want 0", sc); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      random_board(); exp = model_score(); run_scan(lat, sc);
      n_checks++; if (sc != exp) $display("FAIL random_score[%0d]: got %0d want %0d", k, sc, exp); else n_pass++;
    end
  endtask

  task automatic test_mg_contention();
    int n, exp;
    bit exp_gnt, prev_gnt;
    logic [5:0] exp_addr;
    random_board(); exp = model_score();
    @(negedge clk); bus.start = 1'b1; bus.mg_req = 1'b1; bus.mg_addr = 6'($urandom_range(0, 63));
    prev_gnt = 1'b1;  // idle cycle: generator owns the port
    n = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0; n++;
      bus.mg_addr = 6'($urandom_range(0, 63));
      #1;
      if (n <= 320) begin
        exp_gnt  = (n % 5) != 0;
        exp_addr = exp_gnt ? bus.mg_addr : 6'(n / 5 - 1);
        n_checks++; if (bus.mg_gnt !== exp_gnt) $display("FAIL contention_mg_gnt@%0d: got %b want %b", n, bus.mg_gnt, exp_gnt); else n_pass++;
        n_checks++; if (bus.ram_addr !== exp_addr) $display("FAIL contention_addr@%0d: got %0d want %0d", n, bus.ram_addr, exp_addr); else n_pass++;
        n_checks++; if (bus.mg_rvalid !== prev_gnt) $display("FAIL contention_rvalid@%0d: got %b want %b", n, bus.mg_rvalid, prev_gnt); else n_pass++;
        prev_gnt = exp_gnt;
      end else if (n == 321) begin
        n_checks++; if (bus.mg_rvalid !== prev_gnt) $display("FAIL contention_rvalid@%0d: got %b want %b", n, bus.mg_rvalid, prev_gnt); else n_pass++;
      end
    end while (bus.done !== 1'b1 && n < 400);
    n_checks++; if (n != 322) $display("FAIL contention_latency: got %0d want 322", n); else n_pass++;
    n_checks++; if (int'($signed(bus.score)) != exp) $display("FAIL contention_score: got %0d want %0d", bus.score, exp); else n_pass++;
    bus.mg_req = 1'b0;
  endtask

  task automatic test_random_contention();
    int n, exp, grants, den, last_n;
    bit ev, exp_gnt;
    for (int run = 0; run < 2; run++) begin
      random_board(); exp = model_score();
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      n = 1; grants = 0; den = 0; last_n = -10;
      forever begin
        bus.mg_req  = ($urandom_range(0, 3) != 0);
        bus.mg_addr = 6'($urandom_range(0, 63));
        #1;
        if (grants < 64) begin
          ev = !bus.mg_req || (den == STARVE_LIMIT);
          if (ev) begin grants++; den = 0; end else den++;
          exp_gnt = bus.mg_req && !ev;
          n_checks++; if (bus.mg_gnt !== exp_gnt) $display("FAIL rand_mg_gnt@%0d: got %b want %b", n, bus.mg_gnt, exp_gnt); else n_pass++;
          if (grants == 64) last_n = n;
        end
        if (bus.done === 1'b1 || n >= 2000) break;
        @(negedge clk); n++;
      end
      n_checks++; if (n != last_n + 2) $display("FAIL rand_latency[%0d]: got %0d want %0d", run, n, last_n + 2); else n_pass++;
      n_checks++; if (int'($signed(bus.score)) != exp) $display("FAIL rand_score[%0d]: got %0d want %0d", run, bus.score, exp); else n_pass++;
    end
    bus.mg_req = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int lat, sc, n, exp;
    bit seen_done;
    clear_board(); board[0] = 4'hC; board[63] = 4'h1;
    run_scan(lat, sc);
    n_checks++; if (sc != -4) $display("FAIL pre_abort_score: got %0d want -4", sc); else n_pass++;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; n = 1;
    while (n < 31) begin @(negedge clk); n++; end
    #1;
    n_checks++; if (bus.ram_addr !== 6'd30) $display("FAIL abort_addr: got %0d want 30", bus.ram_addr); else n_pass++;
    rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.score !== 16'sd0) $display("FAIL abort_score: got %0d want 0", bus.score); else n_pass++;
    seen_done = 1'b0;
    repeat (100) begin @(negedge clk); #1; if (bus.done === 1'b1) seen_done = 1'b1; end
    n_checks++; if (seen_done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", seen_done); else n_pass++;
    random_board(); exp = model_score(); run_scan(lat, sc);
    n_checks++; if (lat != 66) $display("FAIL post_abort_latency: got %0d want 66", lat); else n_pass++;
    n_checks++; if (sc != exp) $display("FAIL post_abort_score: got %0d want %0d", sc, exp); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int lat, sc, sa, sb, n;
    bit held;
    random_board(); sa = model_score(); run_scan(lat, sc);
    n_checks++; if (sc != sa) $display("FAIL ign_first_score: got %0d want %0d", sc, sa); else n_pass++;
    saved = board;
    for (int t = 0; t < 20 && model_score() == sa; t++) random_board();
    if (model_score() == sa) board[0] = (board[0] == 4'h5) ? 4'h1 : 4'h5;
    sb = model_score();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; n = 1; held = 1'b1;
    forever begin
      #1;
      if (bus.done === 1'b1 || n >= 1000) break;
      if (int'($signed(bus.score)) != sa) held = 1'b0;
      @(negedge clk); n++;
      if (n == 10) bus.start = 1'b1;
      if (n == 11) bus.start = 1'b0;
    end
    n_checks++; if (n != 66) $display("FAIL ign_scan_latency: got %0d want 66", n); else n_pass++;
    n_checks++; if (held !== 1'b1) $display("FAIL ign_score_held_a: got %b want 1", held); else n_pass++;
    n_checks++; if (int'($signed(bus.score)) != sb) $display("FAIL ign_second_score: got %0d want %0d", bus.score, sb); else n_pass++;
    bus.start = 1'b1;  // lands in the DONE cycle
    @(negedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL ign_done_start_busy: got %b want 0", bus.busy); else n_pass++;
    board = saved;
    @(negedge clk); bus.start = 1'b0; n = 1; held = 1'b1; #1;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL restart_busy: got %b want 1", bus.busy); else n_pass++;
    while (bus.done !== 1'b1 && n < 1000) begin
      if (int'($signed(bus.score)) != sb) held = 1'b0;
      @(negedge clk); n++; #1;
    end
    n_checks++; if (n != 66) $display("FAIL restart_latency: got %0d want 66", n); else n_pass++;
    n_checks++; if (held !== 1'b1) $display("FAIL restart_score_held_b: got %b want 1", held); else n_pass++;
    n_checks++; if (int'($signed(bus.score)) != sa) $display("FAIL restart_score: got %0d want %0d", bus.score, sa); else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0; bus.mg_req = 1'b0; bus.mg_addr = '0;
    clear_board();
    test_reset();
    test_empty_latency();
    test_material();
    test_mg_contention();
    test_random_contention();
    test_reset_mid_scan();
    test_start_ignored();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
